// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank with shared prescaler/period counter and double-buffered duty/period
module pwm_bank #(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] ch_out,
  output logic              period_start
);

  logic                  run;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [CNT_W-1:0]      period_pend;
  logic [CNT_W-1:0]      period_act;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_CH-1:0]     out_en;
  logic [NUM_CH-1:0]     pwm_en;
  logic [CNT_W-1:0]      duty_pend [NUM_CH];
  logic [CNT_W-1:0]      duty_act  [NUM_CH];

  logic                  tick;
  logic                  wrap;
  logic                  load;
  logic [CNT_W-1:0]      period_next;
  logic [CNT_W-1:0]      duty_next [NUM_CH];
  logic [15:0]           rd_val;

  assign tick = run && (pre_cnt == prescale);
  assign wrap = tick && (cnt == period_act);
  // Shadows are transparent while stopped, otherwise they load only on wrap.
  assign load = !run || wrap;

  // Post-write pending values, so a write coinciding with a load is captured by it.
  always_comb begin
    period_next = period_pend;
    if (wr_en && wr_addr == 8'h02) period_next = wr_data[CNT_W-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      duty_next[i] = duty_pend[i];
      if (wr_en && wr_addr == 8'(8'h40 + i)) duty_next[i] = wr_data[CNT_W-1:0];
    end
  end

  // Register writes: unshadowed controls plus pending duty/period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      prescale    <= '0;
      out_en      <= '0;
      pwm_en      <= '0;
      period_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_pend[i] <= '0;
    end else begin
      period_pend <= period_next;
      for (int i = 0; i < NUM_CH; i++) duty_pend[i] <= duty_next[i];
      if (wr_en) begin
        if (wr_addr == 8'h00) run      <= wr_data[0];
        if (wr_addr == 8'h01) prescale <= wr_data[PRESCALE_W-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == 8'(8'h20 + i)) begin
            out_en[i] <= wr_data[0];
            pwm_en[i] <= wr_data[1];
          end
        end
      end
    end
  end

  // Active shadows follow the pending registers at load points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
    end else if (load) begin
      period_act <= period_next;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_next[i];
    end
  end

  // Prescaler and period counter, both held at zero while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (!run) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      cnt     <= wrap ? '0 : cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Registered channel outputs and period pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out       <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      for (int i = 0; i < NUM_CH; i++)
        ch_out[i] <= out_en[i] && (!pwm_en[i] || (cnt < duty_act[i]));
    end
  end

  // Read mux over the programmed (pending) values; unmapped addresses read 0.
  always_comb begin
    rd_val = '0;
    case (rd_addr)
      8'h00:   rd_val = {15'b0, run};
      8'h01:   rd_val = 16'(prescale);
      8'h02:   rd_val = 16'(period_pend);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_addr == 8'(8'h20 + i)) rd_val = {14'b0, pwm_en[i], out_en[i]};
          if (rd_addr == 8'(8'h40 + i)) rd_val = 16'(duty_pend[i]);
        end
      end
    endcase
  end

  // One-cycle read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_val : '0;
    end
  end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised successor to the single-register-set PWM peripheral.
- Drives NUM_CH independent PWM outputs from one shared prescaler and period counter.
- Each channel has its own enable bits and duty register. Duty and period updates are double-buffered so they apply glitch-free at period boundaries.
- Sits behind the SPI register peripheral and is programmed through a simple write/read register port.

Parameters:
- NUM_CH, 16, number of PWM channels (1..32).
- CNT_W, 8, counter/period/duty resolution in bits (4..16).
- PRESCALE_W, 8, prescaler reload width (1..16).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  register write strobe, one cycle per write
- wr_addr  input  8  write address
- wr_data  input  16  write data; only low bits are used per register
- rd_en  input  1  register read strobe
- rd_addr  input  8  read address
- rd_data  output  16  read data, valid the cycle after rd_en
- rd_valid  output  1  one-cycle pulse aligned with rd_data
- ch_out  output  NUM_CH  registered PWM outputs
- period_start  output  1  one-cycle pulse when the counter wraps to 0

Behaviour:
- Reset (async assert, sync release): all registers, shadows, counters, ch_out, rd_data, rd_valid and period_start are 0.
- Register map (8-bit address):
  - 0x00 CTRL: bit0 run.
  - 0x01 PRESCALE: low PRESCALE_W bits.
  - 0x02 PERIOD: low CNT_W bits.
  - 0x20+i CFG[i]: bit0 out_en, bit1 pwm_en.
  - 0x40+i DUTY[i]: low CNT_W bits.
  - Writes to unmapped addresses, or with i >= NUM_CH, are ignored. Reads of those addresses return 0.
  - Unused wr_data bits are discarded; reads zero-extend.
- Prescaler:
  - When run=1, prescale counter counts 0..PRESCALE.
  - tick is asserted when the counter equals PRESCALE; the counter then reloads 0.
  - PRESCALE=0 means tick every cycle.
- Period counter:
  - Advances on tick.
  - When counter == period_active and tick, it wraps to 0, period_start pulses high for that cycle, and shadows load.
- Shadows:
  - DUTY[i] and PERIOD writes land in pending registers.
  - duty_active[i] and period_active load from pending only on wrap.
  - A write in the same cycle as a wrap is captured by that wrap (pending update and load use the post-write value).
  - CFG and PRESCALE take effect the next cycle, unshadowed.
- run=0:
  - Prescaler and counter are held at 0; period_start stays 0.
  - Shadows load every cycle, i.e. they are transparent.
  - Clearing run mid-period resets the counter to 0 the next cycle.
- Output, per channel, registered (ch_out reflects counter state one cycle late):
  - out_en=0 -> 0.
  - out_en=1, pwm_en=0 -> 1.
  - out_en=1, pwm_en=1 -> (counter < duty_active[i]).
  - Consequences: duty 0 -> constant 0; duty > period_active -> constant 1; high time is duty ticks per (period+1) ticks.
- Reads:
  - rd_data returns pending (programmed) values, not active shadows.
  - Latency is 1 cycle, rd_valid=1 for one cycle.
  - Simultaneous wr_en and rd_en to the same address returns the old value.
- Arithmetic: all compares are unsigned at CNT_W bits; no saturation is needed.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-operation with run=1, DUTY[0]=0x80.
  - Required: ch_out=0, counter=0 immediately (async). After release, all reads return 0.
- Basic PWM:
  - Stimulus: PRESCALE=0, PERIOD=9, CFG[3]=3, DUTY[3]=4, run=1.
  - Required: ch_out[3] high 4 cycles, low 6 cycles, repeating every 10. period_start pulses every 10 cycles.
- Prescale and static modes:
  - Stimulus: PRESCALE=2, PERIOD=3, DUTY[1]=2, CFG[1]=3.
  - Required: period = 12 clocks with 6 high. CFG[2]=1 gives ch_out[2]=1 constant. CFG=0 gives 0.
- Shadow update:
  - Stimulus: with PERIOD=9, DUTY=4 running, write DUTY=7 at counter=2.
  - Required: the current period still has 4 high; the next period has 7 high. A write on the wrap cycle takes effect in that new period.
- Boundaries:
  - DUTY=0 -> always 0.
  - DUTY=10 with PERIOD=9 -> always 1.
  - PERIOD=0, DUTY=1 -> always 1 and period_start every tick.
  - Write to 0x20+NUM_CH is ignored and reads 0.
- Readback:
  - Stimulus: write DUTY[5]=0xA5, then rd_en at 0x45.
  - Required: next cycle rd_valid=1, rd_data=0x00A5. Same-cycle write/read to 0x45 returns the prior value.
